// File: rtl/ntt_job_arbiter.sv
// rtl/ntt_job_arbiter.sv - two-requester round-robin job arbiter for a shared NTT core
// Sequences clear/launch/run of the core, muxes the polynomial bank and watches for hangs.
module ntt_job_arbiter #(
  parameter int          LOGN    = 8,
  parameter int          BANK_W  = 2,
  parameter int          CLR_CYC = 2,
  parameter int unsigned TIMEOUT = 65535,
  localparam int         AW      = (LOGN < 9) ? 10 : LOGN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            req_intt,
  input  logic [2*BANK_W-1:0]   req_bank,
  output logic [1:0]            ack,
  output logic [1:0]            err,
  output logic                  busy,
  output logic                  core_rst,
  output logic                  core_start,
  output logic                  core_intt,
  input  logic                  core_finish,
  input  logic [AW-1:0]         core_rd_addr,
  input  logic [AW-1:0]         core_wr_addr,
  input  logic                  core_wea,
  output logic [BANK_W+AW-1:0]  mem_rd_addr,
  output logic [BANK_W+AW-1:0]  mem_wr_addr,
  output logic                  mem_we
);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, DONE, FAIL} state_t;

  state_t              state;
  logic                last_grant;
  logic                grant;
  logic                pick;
  logic [BANK_W-1:0]   bank;
  logic [31:0]         clr_cnt;
  logic [31:0]         wdog;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    pick = req[1];
    if (req[0] && req[1]) pick = ~last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      ack        <= 2'b00;
      err        <= 2'b00;
      busy       <= 1'b0;
      core_rst   <= 1'b1;
      core_start <= 1'b0;
      core_intt  <= 1'b0;
      bank       <= '0;
      clr_cnt    <= '0;
      wdog       <= '0;
    end else begin
      ack <= 2'b00;
      err <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= pick;
            core_intt <= req_intt[pick];
            bank      <= pick ? req_bank[2*BANK_W-1:BANK_W] : req_bank[BANK_W-1:0];
            clr_cnt   <= '0;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == 32'(CLR_CYC - 1)) begin
            core_rst   <= 1'b0;
            core_start <= 1'b1;
            state      <= LAUNCH;
          end else begin
            clr_cnt <= clr_cnt + 32'd1;
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= RUN;
        end
        RUN: begin
          // A finish arriving on the timeout cycle still counts as success.
          if (core_finish) begin
            ack        <= grant ? 2'b10 : 2'b01;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            state      <= DONE;
          end else if (wdog == TIMEOUT) begin
            err        <= grant ? 2'b10 : 2'b01;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            state      <= FAIL;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        DONE, FAIL: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd_addr = {bank, core_rd_addr};
  assign mem_wr_addr = {bank, core_wr_addr};
  assign mem_we      = core_wea & (state == RUN);

endmodule

// File: doc/ntt_job_arbiter.md
NTT_JOB_ARBITER -- requirements
Module: ntt_job_arbiter

Interface
REQ-001 SHALL have parameter LOGN, default 8, log2 of polynomial length; AW = (LOGN<9 ? 10 : LOGN) is the core address width.
REQ-002 SHALL have parameter BANK_W, default 2, polynomial-bank select width.
REQ-003 SHALL have parameter CLR_CYC, default 2, core-clear length in cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 65535, RUN watchdog limit in cycles (<2^32).
REQ-005 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester job request, level, held until ack or err
- req_intt  in  2  per-requester transform select, 1 = inverse
- req_bank  in  2*BANK_W  requester i bank at [i*BANK_W +: BANK_W]
- ack  out  2  one-cycle job-complete pulse to granted requester
- err  out  2  one-cycle timeout pulse to granted requester
- busy  out  1  high while state != IDLE
- core_rst  out  1  synchronous clear to NTT memory wrapper
- core_start  out  1  start level to wrapper
- core_intt  out  1  intt select to wrapper
- core_finish  in  1  wrapper finish level
- core_rd_addr  in  AW  wrapper read address
- core_wr_addr  in  AW  wrapper write address
- core_wea  in  1  wrapper write enable
- mem_rd_addr  out  BANK_W+AW  {bank, core_rd_addr}
- mem_wr_addr  out  BANK_W+AW  {bank, core_wr_addr}
- mem_we  out  1  gated write enable

Function
REQ-006 SHALL implement FSM states IDLE, CLEAR, LAUNCH, RUN, DONE, FAIL.
REQ-007 IDLE: any req bit high -> latch grant g, req_intt[g], bank of g; next CLEAR.
REQ-008 Arbitration SHALL be round-robin: if both request, grant the one != last_grant; single requester granted directly.
REQ-009 CLEAR SHALL last exactly CLR_CYC cycles, then LAUNCH; LAUNCH SHALL last one cycle, then RUN.
REQ-010 core_rst SHALL be 1 in IDLE, CLEAR, DONE, FAIL and 0 in LAUNCH, RUN.
REQ-011 core_start SHALL be 1 in LAUNCH and RUN only.
REQ-012 core_intt and bank SHALL hold the latched values from CLEAR through DONE/FAIL and be unchanged in IDLE.
REQ-013 RUN: 32-bit watchdog cleared in LAUNCH, +1 per RUN cycle; core_finish=1 -> DONE; else count == TIMEOUT -> FAIL.
REQ-014 core_finish and timeout in the same cycle SHALL go to DONE (finish wins).
REQ-015 core_finish SHALL be ignored outside RUN.
REQ-016 DONE: ack[g]=1 for one cycle, last_grant <= g, next IDLE.
REQ-017 FAIL: err[g]=1 for one cycle, last_grant <= g, next IDLE; requester remains eligible if req stays high.
REQ-018 req deassertion after grant SHALL be ignored; job completes and ack/err still pulses.
REQ-019 Requests SHALL be sampled only in IDLE; minimum one IDLE cycle between jobs.
REQ-020 mem_rd_addr/mem_wr_addr SHALL be combinational concatenations; mem_we = core_wea AND state==RUN.
REQ-021 Latency: req high in IDLE at edge t -> CLEAR at t+1, LAUNCH at t+1+CLR_CYC, RUN at t+2+CLR_CYC; ack in the cycle after core_finish is sampled.

Reset
REQ-022 rst=1 SHALL immediately, without a clock edge, force: state IDLE, last_grant=1, ack=0, err=0, busy=0, core_rst=1, core_start=0, core_intt=0, bank=0, watchdog=0.
REQ-023 Reset mid-job SHALL abort with no ack/err; first grant after reset goes to requester 0 if both request.

Verification
REQ-024 req=01, req_intt=00, bank0=2, CLR_CYC=2, finish after 300 RUN cycles -> core_rst high 2 cycles post-grant, core_start rises, mem_rd_addr[MSBs]=2, ack=01 one cycle after finish, busy=0 after.
REQ-025 req=11 from reset, req_intt=10 -> requester 0 served (core_intt=0), ack=01; then requester 1 (core_intt=1), ack=10.
REQ-026 TIMEOUT=100, core_finish held 0 -> err[g]=1 at RUN count 100, no ack, return to IDLE with core_rst=1, same requester regranted.
REQ-027 TIMEOUT=100, core_finish rises at count 100 -> ack pulses, err stays 0.
REQ-028 rst pulsed mid-RUN between clock edges -> busy=0, core_rst=1, core_start=0 asynchronously; no ack/err.
REQ-029 core_wea=1 while IDLE or CLEAR -> mem_we=0; core_wea=1 in RUN -> mem_we=1.
